// File: rtl/measure_unit_pkg.sv
// measure_unit_pkg
//   Shared definitions for the skew measurement sweep logic: default widths,
//   the sweep FSM state encoding and the GAP length between samples.
package measure_unit_pkg;

    localparam int CODE_W_DEF  = 10;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 1_000_000;

    // Number of cycles the run level is dropped between samples so the
    // measurement controller sees a clean re-arm.
    localparam int GAP_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_STORE,
        ST_GAP
    } skew_state_t;

endpackage

// File: rtl/skew_stat_acc.sv
// skew_stat_acc
//   Running minimum / maximum / sum / count of accepted delay codes.
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset
//     i_clear        clear all statistics (start of a new sweep)
//     i_valid        accept i_code into the statistics this cycle
//     i_code         delay code to accumulate
//     o_min, o_max   minimum / maximum accepted code (0 while nothing accepted)
//     o_sum          sum of accepted codes, wide enough never to wrap
//     o_n            number of accepted codes
module skew_stat_acc
    import measure_unit_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [CODE_W-1:0]       i_code,
    output logic [CODE_W-1:0]       o_min,
    output logic [CODE_W-1:0]       o_max,
    output logic [CODE_W+CNT_W-1:0] o_sum,
    output logic [CNT_W:0]          o_n
);

    // Internal tracker starts at all-ones so the first accepted code always
    // becomes the minimum; the visible r_min stays 0 until a code arrives.
    logic [CODE_W-1:0]       r_min_trk;
    logic [CODE_W-1:0]       r_min;
    logic [CODE_W-1:0]       r_max;
    logic [CODE_W+CNT_W-1:0] r_sum;
    logic [CNT_W:0]          r_n;

    logic [CODE_W-1:0]       w_new_min;
    logic [CODE_W-1:0]       w_new_max;

    assign w_new_min = (i_code < r_min_trk) ? i_code : r_min_trk;
    assign w_new_max = (i_code > r_max)     ? i_code : r_max;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_min_trk <= '1;
            r_min     <= '0;
            r_max     <= '0;
            r_sum     <= '0;
            r_n       <= '0;
        end else if (i_valid) begin
            r_min_trk <= w_new_min;
            r_min     <= w_new_min;
            r_max     <= w_new_max;
            r_sum     <= r_sum + (CODE_W+CNT_W)'(i_code);
            r_n       <= r_n + (CNT_W+1)'(1);
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;
    assign o_sum = r_sum;
    assign o_n   = r_n;

endmodule

// File: rtl/skew_accum.sv
// skew_accum
//   Runs a sweep of N skew measurements through an external measurement
//   controller and accumulates min / max / sum / count of the returned codes.
//   Ports:
//     wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//     start_i, abort_i         one-cycle pulses: begin sweep / end sweep
//     count_i                  samples per sweep (0 means 2^CNT_W)
//     mes_run_o                run level to the measurement controller
//     mes_rdy_i, mes_err_i,
//     mes_code_i               controller result handshake and data
//     busy_o, done_o, err_o    sweep status (done/err sticky until next start)
//     min_o, max_o, sum_o, n_o accumulated statistics
module skew_accum
    import measure_unit_pkg::*;
#(
    parameter int CODE_W  = CODE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [CNT_W-1:0]        count_i,
    output logic                    mes_run_o,
    input  logic                    mes_rdy_i,
    input  logic                    mes_err_i,
    input  logic [CODE_W-1:0]       mes_code_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [CODE_W-1:0]       min_o,
    output logic [CODE_W-1:0]       max_o,
    output logic [CODE_W+CNT_W-1:0] sum_o,
    output logic [CNT_W:0]          n_o
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    skew_state_t        r_state;
    logic [CNT_W:0]     r_n_req;
    logic [CNT_W:0]     r_n_proc;
    logic [TMO_W-1:0]   r_tmo;
    logic [0:0]         r_gap;
    logic               r_rdy_q;
    logic [CODE_W-1:0]  r_code;
    logic               r_smp_err;
    logic               r_run;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_rdy_rise;
    logic               w_start;
    logic               w_last;
    logic               w_acc_valid;
    logic [CNT_W:0]     w_n_req;

    // Only a 0->1 transition of the ready level counts; a level that is
    // already high when WAIT is entered is ignored until it drops.
    assign w_rdy_rise  = mes_rdy_i && !r_rdy_q;

    // Abort wins over a simultaneous start.
    assign w_start     = (r_state == ST_IDLE) && start_i && !abort_i;

    assign w_last      = ((r_n_proc + (CNT_W+1)'(1)) == r_n_req);

    // Error samples are counted toward N but never reach the statistics;
    // an abort landing on STORE leaves the results untouched.
    assign w_acc_valid = (r_state == ST_STORE) && !r_smp_err && !abort_i && !wb_rst_i;

    assign w_n_req     = (count_i == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count_i};

    always_ff @(posedge wb_clk_i) begin
        r_rdy_q <= mes_rdy_i;
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_n_req   <= '0;
            r_n_proc  <= '0;
            r_tmo     <= '0;
            r_gap     <= '0;
            r_code    <= '0;
            r_smp_err <= 1'b0;
            r_run     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else if (abort_i && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_n_req  <= w_n_req;
                        r_n_proc <= '0;
                        r_done   <= 1'b0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_run    <= 1'b1;
                        r_state  <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_rdy_rise) begin
                        r_code    <= mes_code_i;
                        r_smp_err <= mes_err_i;
                        r_state   <= ST_STORE;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        // Last allowed WAIT cycle expired without a result.
                        r_err   <= 1'b1;
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_STORE: begin
                    r_n_proc <= r_n_proc + (CNT_W+1)'(1);
                    if (r_smp_err) begin
                        r_err <= 1'b1;
                    end
                    r_run <= 1'b0;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == 1'(GAP_CYCLES - 1)) begin
                        r_run   <= 1'b1;
                        r_state <= ST_ARM;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_run   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    skew_stat_acc #(
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W)
    ) u_stat (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_clear (w_start),
        .i_valid (w_acc_valid),
        .i_code  (r_code),
        .o_min   (min_o),
        .o_max   (max_o),
        .o_sum   (sum_o),
        .o_n     (n_o)
    );

    assign mes_run_o = r_run;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule

// File: tb/tb_skew_accum.sv
module tb_skew_accum;

    localparam int CODE_W  = 10;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 100;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        count;
    logic                    mes_run;
    logic                    mes_rdy;
    logic                    mes_err;
    logic [CODE_W-1:0]       mes_code;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [CODE_W-1:0]       min_v;
    logic [CODE_W-1:0]       max_v;
    logic [CODE_W+CNT_W-1:0] sum_v;
    logic [CNT_W:0]          n_v;

    skew_accum #(
        .CODE_W  (CODE_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .abort_i    (abort),
        .count_i    (count),
        .mes_run_o  (mes_run),
        .mes_rdy_i  (mes_rdy),
        .mes_err_i  (mes_err),
        .mes_code_i (mes_code),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .min_o      (min_v),
        .max_o      (max_v),
        .sum_o      (sum_v),
        .n_o        (n_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic done;
        logic err;
        int   mn;
        int   mx;
        int   sm;
        int   n;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;
    logic prev_busy = 1'b0;
    int   gap_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic d, input logic e, input int mn, input int mx,
                            input int sm, input int n);
        exp_t x;
        x.done = d; x.err = e; x.mn = mn; x.mx = mx; x.sm = sm; x.n = n;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: every sweep end (busy falling) is one response.
    always @(negedge clk) begin
        if (mon_en && prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got 1 expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done", 32'(done), 32'(e.done));
                check("err",  32'(err),  32'(e.err));
                check("min",  32'(min_v), e.mn);
                check("max",  32'(max_v), e.mx);
                check("sum",  32'(sum_v), e.sm);
                check("n",    32'(n_v),   e.n);
                check("run_low_at_end", 32'(mes_run), 0);
            end
        end
        prev_busy <= busy;
    end

    // Run level must be low for exactly two cycles between samples.
    always @(negedge clk) begin
        if (mon_en && busy && !mes_run) begin
            gap_len <= gap_len + 1;
        end else if (mon_en && busy && mes_run && gap_len > 0) begin
            check("gap_len", gap_len, 2);
            gap_len <= 0;
        end else if (!busy) begin
            gap_len <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input logic lvl, input string name);
        int k;
        k = 0;
        while (mes_run !== lvl && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) check(name, 32'(mes_run), 32'(lvl));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) check("wait_idle", 32'(busy), 0);
        tick();
        tick();
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] c);
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Controller model: respond lat cycles into the run window, hold the
    // result until the run level drops.
    task automatic do_sample(input logic [CODE_W-1:0] code, input logic e, input int lat);
        wait_run(1'b1, "run_high_timeout");
        repeat (lat) tick();
        mes_code = code;
        mes_err  = e;
        mes_rdy  = 1'b1;
        wait_run(1'b0, "run_low_timeout");
        mes_rdy  = 1'b0;
        mes_err  = 1'b0;
    endtask

    initial begin
        int runcyc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; count = '0;
        mes_rdy = 1'b0; mes_err = 1'b0; mes_code = '0;
        repeat (3) tick();
        check("rst_run",  32'(mes_run), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err), 0);
        check("rst_min",  32'(min_v), 0);
        check("rst_max",  32'(max_v), 0);
        check("rst_sum",  32'(sum_v), 0);
        check("rst_n",    32'(n_v), 0);
        rst = 1'b0;
        tick();

        // Reset mid-sweep with start asserted: reset wins.
        pulse_start(8'd2);
        do_sample(10'd33, 1'b0, 1);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_run",  32'(mes_run), 0);
        check("midrst_sum",  32'(sum_v), 0);
        check("midrst_n",    32'(n_v), 0);
        tick();
        check("midrst_idle", 32'(busy), 0);
        tick();
        mon_en = 1'b1;

        // Four samples, mixed codes.
        push_exp(1'b1, 1'b0, 50, 300, 650, 4);
        pulse_start(8'd4);
        do_sample(10'd100, 1'b0, 1);
        do_sample(10'd50,  1'b0, 3);
        do_sample(10'd300, 1'b0, 2);
        do_sample(10'd200, 1'b0, 1);
        wait_idle();

        // Middle sample flagged bad: counted, discarded.
        push_exp(1'b1, 1'b1, 10, 20, 30, 2);
        pulse_start(8'd3);
        do_sample(10'd10,  1'b0, 2);
        do_sample(10'd999, 1'b1, 1);
        do_sample(10'd20,  1'b0, 4);
        wait_idle();

        // Full 256-sample sweep of full-scale code.
        push_exp(1'b1, 1'b0, 1023, 1023, 261888, 256);
        pulse_start(8'd0);
        for (int i = 0; i < 256; i++) begin
            do_sample(10'd1023, 1'b0, 1 + (i % 3));
        end
        wait_idle();

        // Timeout: ready never rises; ARM + 100 WAIT cycles with run high.
        push_exp(1'b0, 1'b1, 0, 0, 0, 0);
        pulse_start(8'd2);
        runcyc = 0;
        while (busy === 1'b1 && runcyc < 300) begin
            if (mes_run === 1'b1) runcyc++;
            tick();
        end
        check("timeout_run_cycles", runcyc, TIMEOUT + 1);
        wait_idle();

        // Abort during the second GAP; only the first sample was accepted.
        push_exp(1'b0, 1'b1, 77, 77, 77, 1);
        pulse_start(8'd4);
        do_sample(10'd77,  1'b0, 1);
        do_sample(10'd500, 1'b1, 2);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_run",  32'(mes_run), 0);
        check("abort_done", 32'(done), 0);
        check("abort_held_sum", 32'(sum_v), 77);
        tick();
        tick();
        push_exp(1'b1, 1'b0, 5, 5, 5, 1);
        pulse_start(8'd1);
        check("restart_clr_n",   32'(n_v), 0);
        check("restart_clr_sum", 32'(sum_v), 0);
        check("restart_clr_min", 32'(min_v), 0);
        check("restart_clr_err", 32'(err), 0);
        do_sample(10'd5, 1'b0, 1);
        wait_idle();

        // Ready stuck high through ARM must not be taken as a result.
        push_exp(1'b1, 1'b0, 123, 123, 123, 1);
        pulse_start(8'd1);
        mes_code = 10'd700;
        mes_rdy  = 1'b1;
        repeat (6) tick();
        check("stuck_busy", 32'(busy), 1);
        check("stuck_n",    32'(n_v), 0);
        mes_rdy = 1'b0;
        tick();
        mes_code = 10'd123;
        mes_rdy  = 1'b1;
        wait_run(1'b0, "stuck_run_low_timeout");
        mes_rdy = 1'b0;
        wait_idle();

        // Start while busy is ignored: second start mid-sweep changes nothing.
        push_exp(1'b1, 1'b0, 3, 9, 12, 2);
        pulse_start(8'd2);
        do_sample(10'd9, 1'b0, 1);
        start = 1'b1; count = 8'd7;
        tick();
        start = 1'b0;
        do_sample(10'd3, 1'b0, 2);
        wait_idle();

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skew_accum.md
SKEW_ACCUM -- requirements
Module: skew_accum

Interface
REQ-001 Parameter CODE_W, default 10, width of the delay-code result from the skew measurement controller.
REQ-002 Parameter CNT_W, default 8, width of the sample-count request.
REQ-003 Parameter TIMEOUT, default 1_000_000, maximum wb_clk_i cycles allowed per sample.
REQ-004 wb_clk_i  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  one-cycle pulse; clears results and begins a sweep.
REQ-007 abort_i  in  1  one-cycle pulse; ends the sweep and returns to IDLE.
REQ-008 count_i  in  CNT_W  number of samples N, sampled on start_i; 0 means 2^CNT_W.
REQ-009 mes_run_o  out  1  run level to the skew measurement controller.
REQ-010 mes_rdy_i  in  1  controller ready/result-valid level.
REQ-011 mes_err_i  in  1  controller error level, qualified with mes_rdy_i.
REQ-012 mes_code_i  in  CODE_W  measured delay code, valid while mes_rdy_i=1.
REQ-013 busy_o  out  1  high from the cycle after start_i until completion.
REQ-014 done_o  out  1  sticky; set on normal completion, cleared by start_i or reset.
REQ-015 err_o  out  1  sticky; set on timeout or any sample with mes_err_i=1.
REQ-016 min_o / max_o  out  CODE_W  minimum / maximum accepted code.
REQ-017 sum_o  out  CODE_W+CNT_W  sum of accepted codes.
REQ-018 n_o  out  CNT_W+1  number of accepted samples.

Function
REQ-019 FSM states SHALL be IDLE, ARM, WAIT, STORE, GAP.
REQ-020 IDLE: on start_i, latch N, clear the accumulators, and go to ARM.
REQ-021 ARM: drive mes_run_o=1, clear the timeout counter, and go to WAIT.
REQ-022 WAIT: mes_run_o=1; on a rising edge of mes_rdy_i, capture mes_code_i and mes_err_i and go to STORE.
REQ-023 STORE, error-free sample: update min, max, sum, and n.
REQ-024 STORE, sample with mes_err_i=1: discard the sample, set err_o, and still count it toward N.
REQ-025 STORE, next state: go to IDLE with done_o=1 if N samples have been processed, else go to GAP.
REQ-026 GAP: drive mes_run_o=0 for exactly 2 cycles, then go to ARM, so the controller re-arms.
REQ-027 Timeout: if the timeout counter reaches TIMEOUT in WAIT, set err_o, drive mes_run_o=0, and go to IDLE; done_o stays 0.
REQ-028 min SHALL initialise to all-ones and max to 0, so the first accepted sample sets both.
REQ-029 If no sample is accepted, min_o/max_o SHALL read 0 (n_o=0 gates the outputs).
REQ-030 Sum SHALL never wrap: the CODE_W+CNT_W width covers 2^CNT_W samples of full-scale code.
REQ-031 abort_i in any non-IDLE state SHALL go to IDLE next cycle with mes_run_o=0 and done_o=0; results are held.
REQ-032 start_i while busy SHALL be ignored; start_i and abort_i together: abort wins.
REQ-033 mes_rdy_i high on entry to WAIT is not an edge; only a 0->1 transition SHALL be accepted.
REQ-034 Outputs SHALL be registered; results update one cycle after STORE.
REQ-035 Sample-to-sample period SHALL be controller latency + 4 cycles.

Reset
REQ-036 On wb_rst_i=1: FSM=IDLE; mes_run_o, busy_o, done_o, err_o=0; sum_o, n_o, min_o, max_o=0.
REQ-037 Reset mid-sweep SHALL override every other input that cycle.

Structure
REQ-038 The FSM state enum and the default widths SHALL live in shared package measure_unit_pkg.
REQ-039 Min/max/sum update SHALL be one sub-module, skew_stat_acc (clear, valid, code in; min/max/sum/n out).
REQ-040 Target size is 150-300 lines of RTL.

Verification
REQ-041 count_i=4; codes 100,50,300,200, one per rdy pulse -> done_o=1, min=50, max=300, sum=650, n=4, err_o=0.
REQ-042 count_i=0; 256 samples of code 1023 -> sum=261888, n=256, no wrap, done_o=1.
REQ-043 count_i=3; second sample has mes_err_i=1 -> err_o=1, done_o=1, n=2, sum = first + third code.
REQ-044 TIMEOUT=100; mes_rdy_i held 0 -> err_o=1 at cycle 100 of WAIT, mes_run_o=0, done_o=0, FSM=IDLE.
REQ-045 abort_i during the 2nd GAP -> IDLE next cycle, busy_o=0, results of the first sample held; a new start_i clears them.
REQ-046 mes_rdy_i stuck high through ARM -> no sample accepted until it falls and rises again; mes_run_o low for exactly 2 cycles per GAP.
